// File: rtl/btb_storage_ctrl_pkg.sv
// Shared constants, types and field helpers for the BTB storage/control block.
package btb_storage_ctrl_pkg;

  localparam int NUM_SETS = 8;
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = 27;
  localparam int PC_W     = 32;
  localparam int SET_W    = 128;
  localparam int WAY_W    = 64;

  // PC field positions
  localparam int PC_IDX_LSB = 2;
  localparam int PC_TAG_LSB = 5;

  // Set / way bit-field offsets
  localparam int WAY1_LSB      = 64;
  localparam int WAY2_LSB      = 0;
  localparam int WAY_VALID_BIT = 63;
  localparam int WAY_TAG_LSB   = 36;
  localparam int WAY_TGT_LSB   = 4;
  localparam int WAY_ST_LSB    = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

  // Flush controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  // 2-bit predictor state encodings used by the external update logic
  localparam logic [1:0] PRED_STRONG_NT = 2'b00;
  localparam logic [1:0] PRED_WEAK_NT   = 2'b01;
  localparam logic [1:0] PRED_WEAK_T    = 2'b10;
  localparam logic [1:0] PRED_STRONG_T  = 2'b11;

  // One-deep update stage between EX resolve and the storage write
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [PC_W-1:0]  target;
    logic             mispredicted;
  } pending_t;

  function automatic logic [IDX_W-1:0] pc_index(input logic [PC_W-1:0] pc);
    return pc[PC_IDX_LSB +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
    return pc[PC_TAG_LSB +: TAG_W];
  endfunction

  function automatic logic way_match(input logic [WAY_W-1:0] way,
                                     input logic [TAG_W-1:0] tag);
    return way[WAY_VALID_BIT] && (way[WAY_TAG_LSB +: TAG_W] == tag);
  endfunction

  function automatic logic [PC_W-1:0] way_target(input logic [WAY_W-1:0] way);
    return way[WAY_TGT_LSB +: PC_W];
  endfunction

  function automatic logic [1:0] way_state(input logic [WAY_W-1:0] way);
    return way[WAY_ST_LSB +: 2];
  endfunction

endpackage

// File: rtl/btb_storage_ctrl_lookup.sv
// Combinational 2-way tag compare with forwarding of the in-flight set write.
module btb_lookup
  import btb_storage_ctrl_pkg::*;
(
  input  logic [PC_W-1:0]  lookup_pc,
  input  logic [SET_W-1:0] stored_set,
  input  logic             fwd_valid,
  input  logic [IDX_W-1:0] fwd_index,
  input  logic [SET_W-1:0] fwd_set,
  input  logic             block,
  output logic             hit,
  output logic             taken,
  output logic [PC_W-1:0]  target
);

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [SET_W-1:0] sel_set_s;
  logic [WAY_W-1:0] way1_s;
  logic [WAY_W-1:0] way2_s;

  // Pick stored or forwarded set, compare both ways, way1 wins a double match
  always_comb begin
    idx_s = pc_index(lookup_pc);
    tag_s = pc_tag(lookup_pc);
    if (fwd_valid && (fwd_index == idx_s)) begin
      sel_set_s = fwd_set;
    end else begin
      sel_set_s = stored_set;
    end
    way1_s = sel_set_s[WAY1_LSB +: WAY_W];
    way2_s = sel_set_s[WAY2_LSB +: WAY_W];
    hit    = 1'b0;
    taken  = 1'b0;
    target = {PC_W{1'b0}};
    if (block) begin
      hit    = 1'b0;
      taken  = 1'b0;
      target = {PC_W{1'b0}};
    end else if (way_match(way1_s, tag_s)) begin
      hit    = 1'b1;
      taken  = way_state(way1_s)[1];
      target = way_target(way1_s);
    end else if (way_match(way2_s, tag_s)) begin
      hit    = 1'b1;
      taken  = way_state(way2_s)[1];
      target = way_target(way2_s);
    end else begin
      hit    = 1'b0;
      taken  = 1'b0;
      target = {PC_W{1'b0}};
    end
  end

endmodule

// File: rtl/btb_storage_ctrl.sv
// BTB set storage, LRU vector, one-cycle update stage and iterative flush.
module btb_storage_ctrl
  import btb_storage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              lookup_hit,
  output logic              lookup_taken,
  output logic [PC_W-1:0]   lookup_target,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic [PC_W-1:0]   update_target,
  input  logic              update_mispredicted,
  input  logic              flush_req,
  output logic              busy,
  output logic [SET_W-1:0]  wr_update_set,
  output logic [NUM_SETS-1:0] wr_lru,
  output logic [TAG_W-1:0]  wr_update_tag,
  output logic [IDX_W-1:0]  wr_update_index,
  output logic [PC_W-1:0]   wr_update_target,
  output logic              wr_mispredicted,
  input  logic [SET_W-1:0]  wr_write_set,
  input  logic              wr_next_lru
);

  flush_state_e     state_r;
  flush_state_e     state_n;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_n;
  pending_t         pend_r;
  pending_t         pend_n;
  logic [SET_W-1:0] sets_r [NUM_SETS];
  logic [NUM_SETS-1:0] lru_r;
  logic             accept_s;
  logic             commit_s;
  logic [SET_W-1:0] lk_stored_set_s;

  // An update is only taken in IDLE, and a simultaneous flush request wins
  assign accept_s = (state_r == ST_IDLE) && update_valid && !flush_req;
  // The pending write is dropped if a flush starts in the same cycle
  assign commit_s = (state_r == ST_IDLE) && pend_r.valid && !flush_req;
  assign busy     = (state_r == ST_FLUSH);

  assign lk_stored_set_s = sets_r[pc_index(lookup_pc)];

  btb_lookup u_lookup (
    .lookup_pc  (lookup_pc),
    .stored_set (lk_stored_set_s),
    .fwd_valid  (pend_r.valid),
    .fwd_index  (pend_r.index),
    .fwd_set    (wr_write_set),
    .block      (busy),
    .hit        (lookup_hit),
    .taken      (lookup_taken),
    .target     (lookup_target)
  );

  // Flush FSM next-state and sweep counter
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) begin
          state_n = ST_FLUSH;
          cnt_n   = {IDX_W{1'b0}};
        end else begin
          state_n = ST_IDLE;
          cnt_n   = cnt_r;
        end
      end
      ST_FLUSH: begin
        if (cnt_r == LAST_IDX) begin
          state_n = ST_IDLE;
          cnt_n   = {IDX_W{1'b0}};
        end else begin
          state_n = ST_FLUSH;
          cnt_n   = cnt_r + IDX_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Next contents of the update stage: capture on accept, otherwise empty
  always_comb begin
    pend_n = pending_t'({$bits(pending_t){1'b0}});
    if (accept_s) begin
      pend_n.valid        = 1'b1;
      pend_n.tag          = pc_tag(update_pc);
      pend_n.index        = pc_index(update_pc);
      pend_n.target       = update_target;
      pend_n.mispredicted = update_mispredicted;
    end else begin
      pend_n.valid = 1'b0;
    end
  end

  // Drive the external set-update logic from the update stage
  always_comb begin
    if (pend_r.valid) begin
      wr_update_set    = sets_r[pend_r.index];
      wr_lru           = lru_r;
      wr_update_tag    = pend_r.tag;
      wr_update_index  = pend_r.index;
      wr_update_target = pend_r.target;
      wr_mispredicted  = pend_r.mispredicted;
    end else begin
      wr_update_set    = {SET_W{1'b0}};
      wr_lru           = {NUM_SETS{1'b0}};
      wr_update_tag    = {TAG_W{1'b0}};
      wr_update_index  = {IDX_W{1'b0}};
      wr_update_target = {PC_W{1'b0}};
      wr_mispredicted  = 1'b0;
    end
  end

  // FSM state, sweep counter and update stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {IDX_W{1'b0}};
      pend_r  <= pending_t'({$bits(pending_t){1'b0}});
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      pend_r  <= pend_n;
    end
  end

  // Set storage and LRU: sweep-clear during flush, else commit the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        sets_r[i] <= {SET_W{1'b0}};
      end
      lru_r <= {NUM_SETS{1'b0}};
    end else if (state_r == ST_FLUSH) begin
      sets_r[cnt_r] <= {SET_W{1'b0}};
      lru_r[cnt_r]  <= 1'b0;
    end else if (commit_s) begin
      sets_r[pend_r.index] <= wr_write_set;
      lru_r[pend_r.index]  <= wr_next_lru;
    end
  end

endmodule

// File: tb/tb_btb_storage_ctrl.sv
// Self-checking bench: table of one-cycle steps plus flush / reset sequences,
// with an independent model of the external set-update logic attached.
module tb_btb_storage_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  lookup_pc = 32'h0;
  logic         lookup_hit;
  logic         lookup_taken;
  logic [31:0]  lookup_target;
  logic         update_valid = 1'b0;
  logic [31:0]  update_pc = 32'h0;
  logic [31:0]  update_target = 32'h0;
  logic         update_mispredicted = 1'b0;
  logic         flush_req = 1'b0;
  logic         busy;
  logic [127:0] wr_update_set;
  logic [7:0]   wr_lru;
  logic [26:0]  wr_update_tag;
  logic [2:0]   wr_update_index;
  logic [31:0]  wr_update_target;
  logic         wr_mispredicted;
  logic [127:0] wr_write_set;
  logic         wr_next_lru;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_storage_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_pc(lookup_pc), .lookup_hit(lookup_hit), .lookup_taken(lookup_taken),
    .lookup_target(lookup_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_mispredicted(update_mispredicted), .flush_req(flush_req), .busy(busy),
    .wr_update_set(wr_update_set), .wr_lru(wr_lru), .wr_update_tag(wr_update_tag),
    .wr_update_index(wr_update_index), .wr_update_target(wr_update_target),
    .wr_mispredicted(wr_mispredicted), .wr_write_set(wr_write_set),
    .wr_next_lru(wr_next_lru)
  );

  // External set-update logic: hit way refreshed, else allocate LRU victim.
  // LRU bit = way to replace next (0: way1, 1: way2). New entries start weak-NT.
  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic mis);
    if (mis) return (s == 2'b00) ? 2'b00 : s - 2'b01;
    else     return (s == 2'b11) ? 2'b11 : s + 2'b01;
  endfunction

  logic [63:0] m_w1, m_w2;
  logic        m_h1, m_h2;
  always_comb begin
    m_w1 = wr_update_set[127:64];
    m_w2 = wr_update_set[63:0];
    m_h1 = m_w1[63] && (m_w1[62:36] == wr_update_tag);
    m_h2 = m_w2[63] && (m_w2[62:36] == wr_update_tag);
    wr_write_set = wr_update_set;
    wr_next_lru  = 1'b0;
    if (m_h1) begin
      wr_write_set[127:64] = {1'b1, wr_update_tag, wr_update_target,
                              sat_step(m_w1[3:2], wr_mispredicted), 2'b00};
      wr_next_lru = 1'b1;
    end else if (m_h2) begin
      wr_write_set[63:0] = {1'b1, wr_update_tag, wr_update_target,
                            sat_step(m_w2[3:2], wr_mispredicted), 2'b00};
      wr_next_lru = 1'b0;
    end else if (!wr_lru[wr_update_index]) begin
      wr_write_set[127:64] = {1'b1, wr_update_tag, wr_update_target, 2'b01, 2'b00};
      wr_next_lru = 1'b1;
    end else begin
      wr_write_set[63:0] = {1'b1, wr_update_tag, wr_update_target, 2'b01, 2'b00};
      wr_next_lru = 1'b0;
    end
  end

  typedef struct {
    string       name;
    logic        upd_v;
    logic [31:0] upd_pc;
    logic [31:0] upd_tgt;
    logic        upd_mis;
    logic        flush;
    logic [31:0] lk_pc;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_tgt;
    logic        exp_busy;
    logic        chk_wr;
    logic [7:0]  exp_lru;
    logic [26:0] exp_tag;
  } vec_t;

  vec_t sb_q[$];

  function automatic vec_t mk(input string nm, input logic uv, input logic [31:0] upc,
                              input logic [31:0] ut, input logic um, input logic [31:0] lpc,
                              input logic h, input logic tk, input logic [31:0] tg,
                              input logic cw, input logic [7:0] lru, input logic [26:0] tag);
    vec_t v;
    v.name = nm; v.upd_v = uv; v.upd_pc = upc; v.upd_tgt = ut; v.upd_mis = um;
    v.flush = 1'b0; v.lk_pc = lpc; v.exp_hit = h; v.exp_taken = tk; v.exp_tgt = tg;
    v.exp_busy = 1'b0; v.chk_wr = cw; v.exp_lru = lru; v.exp_tag = tag;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the DUT now
  task automatic pop_cmp();
    vec_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.name, ".hit"},    {31'd0, lookup_hit},   {31'd0, e.exp_hit});
      check({e.name, ".taken"},  {31'd0, lookup_taken}, {31'd0, e.exp_taken});
      check({e.name, ".target"}, lookup_target,         e.exp_tgt);
      check({e.name, ".busy"},   {31'd0, busy},         {31'd0, e.exp_busy});
      if (e.chk_wr) begin
        check({e.name, ".wr_lru"}, {24'd0, wr_lru},       {24'd0, e.exp_lru});
        check({e.name, ".wr_tag"}, {5'd0, wr_update_tag}, {5'd0, e.exp_tag});
      end
    end
  endtask

  // One cycle: drive after the rising edge, sample on the falling edge
  task automatic apply_step(input vec_t v);
    @(posedge clk); #1;
    update_valid = v.upd_v; update_pc = v.upd_pc; update_target = v.upd_tgt;
    update_mispredicted = v.upd_mis; flush_req = v.flush; lookup_pc = v.lk_pc;
    sb_q.push_back(v);
    @(negedge clk);
    pop_cmp();
  endtask

  vec_t tbl[13];
  vec_t v;
  int   busy_cnt;
  int   flush_lk_bad;

  initial begin
    tbl[0]  = mk("rst_lk40",   1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b0, 1'b0, 32'h0,   1'b0, 8'h00, 27'h0);
    tbl[1]  = mk("upd40_t",    1'b1, 32'h40,  32'h100, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   1'b0, 8'h00, 27'h0);
    tbl[2]  = mk("fwd40",      1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h100, 1'b1, 8'h00, 27'h2);
    tbl[3]  = mk("commit40",   1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h100, 1'b0, 8'h00, 27'h0);
    tbl[4]  = mk("upd40_ok",   1'b1, 32'h40,  32'h100, 1'b0, 32'h440, 1'b0, 1'b0, 32'h0,   1'b0, 8'h00, 27'h0);
    tbl[5]  = mk("upd440",     1'b1, 32'h440, 32'h200, 1'b1, 32'h40,  1'b1, 1'b1, 32'h100, 1'b1, 8'h01, 27'h2);
    tbl[6]  = mk("fwd440",     1'b0, 32'h0,   32'h0,   1'b0, 32'h440, 1'b1, 1'b0, 32'h200, 1'b1, 8'h01, 27'h22);
    tbl[7]  = mk("taken40",    1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b1, 32'h100, 1'b1, 8'h00, 27'h0);
    tbl[8]  = mk("mis40",      1'b1, 32'h40,  32'h100, 1'b1, 32'h440, 1'b1, 1'b0, 32'h200, 1'b0, 8'h00, 27'h0);
    tbl[9]  = mk("fwd_mis40",  1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h100, 1'b1, 8'h00, 27'h2);
    tbl[10] = mk("after_mis",  1'b0, 32'h0,   32'h0,   1'b0, 32'h40,  1'b1, 1'b0, 32'h100, 1'b0, 8'h00, 27'h0);
    tbl[11] = mk("miss_idx1",  1'b0, 32'h0,   32'h0,   1'b0, 32'h44,  1'b0, 1'b0, 32'h0,   1'b0, 8'h00, 27'h0);
    tbl[12] = mk("miss_tag",   1'b0, 32'h0,   32'h0,   1'b0, 32'h840, 1'b0, 1'b0, 32'h0,   1'b0, 8'h00, 27'h0);

    // Reset state, observed while reset is held
    lookup_pc = 32'h40;
    #12;
    check("reset.busy",   {31'd0, busy},       32'd0);
    check("reset.hit",    {31'd0, lookup_hit}, 32'd0);
    check("reset.target", lookup_target,       32'd0);
    check("reset.wr_lru", {24'd0, wr_lru},     32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) apply_step(tbl[i]);

    // Flush with set 0 populated and a concurrent update that must be dropped
    v = mk("flush_req", 1'b1, 32'h840, 32'h900, 1'b0, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 8'h00, 27'h0);
    v.flush = 1'b1;
    apply_step(v);
    busy_cnt = 0;
    flush_lk_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      flush_req    = (i == 2);
      update_valid = (i < 4);
      update_pc    = 32'h440;
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (lookup_hit || lookup_taken || (lookup_target != 32'h0)) flush_lk_bad++;
      end
    end
    update_valid = 1'b0;
    flush_req    = 1'b0;
    check("flush.busy_cycles", busy_cnt, 32'd8);
    check("flush.lookup_blocked", flush_lk_bad, 32'd0);
    apply_step(mk("post_fl40",  1'b0, 32'h0, 32'h0, 1'b0, 32'h40,  1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0));
    apply_step(mk("post_fl440", 1'b0, 32'h0, 32'h0, 1'b0, 32'h440, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0));
    apply_step(mk("post_fl840", 1'b0, 32'h0, 32'h0, 1'b0, 32'h840, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0));
    apply_step(mk("refill40",   1'b1, 32'h40, 32'h180, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0));
    apply_step(mk("lru_clear",  1'b1, 32'h54, 32'h500, 1'b0, 32'h40, 1'b1, 1'b0, 32'h180, 1'b1, 8'h00, 27'h2));
    apply_step(mk("fwd54",      1'b0, 32'h0, 32'h0, 1'b0, 32'h54,  1'b1, 1'b0, 32'h500, 1'b1, 8'h01, 27'h2));
    apply_step(mk("commit54",   1'b0, 32'h0, 32'h0, 1'b0, 32'h54,  1'b1, 1'b0, 32'h500, 1'b0, 8'h00, 27'h0));

    // Reset asserted during flush cycle 3
    v = mk("fl2_req", 1'b0, 32'h0, 32'h0, 1'b0, 32'h54, 1'b1, 1'b0, 32'h500, 1'b0, 8'h00, 27'h0);
    v.flush = 1'b1;
    apply_step(v);
    for (int i = 0; i < 3; i++) begin
      v = mk($sformatf("fl2_c%0d", i), 1'b0, 32'h0, 32'h0, 1'b0, 32'h54, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0);
      v.exp_busy = 1'b1;
      apply_step(v);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", {31'd0, busy},       32'd0);
    check("midrst.hit",  {31'd0, lookup_hit}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    apply_step(mk("rst_miss54", 1'b0, 32'h0, 32'h0, 1'b0, 32'h54, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0));
    apply_step(mk("rst_upd48",  1'b1, 32'h48, 32'h300, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 27'h0));
    apply_step(mk("rst_fwd48",  1'b0, 32'h0, 32'h0, 1'b0, 32'h48, 1'b1, 1'b0, 32'h300, 1'b1, 8'h00, 27'h2));
    apply_step(mk("rst_hit48",  1'b0, 32'h0, 32'h0, 1'b0, 32'h48, 1'b1, 1'b0, 32'h300, 1'b0, 8'h00, 27'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_storage_ctrl.md
Name: btb_storage_ctrl

Overview:
- Storage and control around the 2-way BTB update logic.
- Holds 8 sets × 128 bits plus an 8-bit LRU vector.
- Serves the combinational IF-stage lookup.
- Registers EX-stage update requests for one cycle, drives the external set-update logic, and commits its write_set / next-LRU result.
- Provides an iterative flush FSM and forwards an in-flight write to same-index lookups.

Parameters:
- NUM_SETS, 8, number of sets; the index is log2(NUM_SETS)=3 bits.
- TAG_W, 27, tag width; pc[31:5] is the tag, pc[4:2] the index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lookup_pc  in  32  IF-stage fetch PC
- lookup_hit  out  1  valid tag match in the indexed set
- lookup_taken  out  1  hit and state[1]==1
- lookup_target  out  32  target of the hit way; 0 on miss
- update_valid  in  1  EX resolves a branch this cycle
- update_pc  in  32  resolved branch PC
- update_target  in  32  resolved target
- update_mispredicted  in  1  prediction was wrong
- flush_req  in  1  single-cycle request to invalidate the whole BTB
- busy  out  1  flush in progress
- wr_update_set  out  128  stored set at the pending index
- wr_lru  out  8  full LRU vector
- wr_update_tag  out  27  pending tag
- wr_update_index  out  3  pending index
- wr_update_target  out  32  pending target
- wr_mispredicted  out  1  pending mispredict flag
- wr_write_set  in  128  new set from the update logic
- wr_next_lru  in  1  new LRU bit for the pending index

Behaviour:
- Set layout:
  - way1 in [127:64], way2 in [63:0].
  - Each way = valid[63], tag[62:36], target[35:4], state[3:2], pad[1:0]=00.
- Reset (async, rst_n=0): all sets 0, LRU 0, pending stage invalid, FSM=IDLE, busy=0. Lookup outputs are therefore 0.
- Lookup (combinational, same cycle):
  - Compare tag against both ways of set[lookup_pc[4:2]].
  - Way1 has priority if both match (must not occur).
  - taken = hit && state[1].
- Forwarding: if the pending stage is valid and its index equals the lookup index, the lookup uses wr_write_set instead of the stored set.
- Update pipeline:
  - Cycle t: update_valid=1 in IDLE with no flush_req → capture tag/index/target/mispredicted into the pending stage at the edge ending cycle t.
  - Cycle t+1: drive wr_* from the pending stage and the stored set; at the edge ending t+1, write set[index]=wr_write_set and LRU[index]=wr_next_lru.
- Back-to-back updates:
  - One update is accepted per cycle, with no stall.
  - A second same-index update in t+1 reads the already-committed set in t+2, so there is no hazard.
- When the pending stage is invalid, wr_* outputs are driven to 0 and nothing is written.
- FSM states:
  - IDLE: flush_req=1 → FLUSH, cnt=0. Pending and incoming updates are dropped (flush wins over a simultaneous update).
  - FLUSH: clear set[cnt] and LRU[cnt] each cycle, cnt++. When cnt==NUM_SETS-1, clear it and return to IDLE.
- FLUSH behaviour:
  - busy=1 for exactly NUM_SETS cycles.
  - Lookups report a miss (hit=0, taken=0, target=0).
  - update_valid and flush_req are ignored.
- rst_n asserted mid-flush: immediate return to IDLE with everything cleared.

Decomposition:
- Shared defines header holds:
  - set/way bit-field offsets
  - TAG_W / index constants
  - FSM state encodings IDLE=0, FLUSH=1
  - existing 2-bit predictor state constants
- One sub-module: btb_lookup, the combinational way compare / hit / forward mux.
- The set-update logic stays external, connected through the wr_* ports.

Test Plan:
- Reset, then lookup_pc=0x0000_0040 → hit=0, taken=0, target=0; busy=0.
- update_pc=0x0000_0040, target=0x0000_0100, mispredicted=1, with the update logic attached → two edges later the lookup of 0x40 hits with target 0x100. Same-cycle lookup during t+1 also hits via forwarding.
- Two updates to the same index (pc 0x40 then 0x440) on consecutive cycles → both ways valid; LRU[0] toggles per next_lru; lookups of 0x40 and 0x440 both hit.
- Repeat a correct-prediction update on 0x40 until state MSB=1 → lookup_taken=1; a mispredict update moves the state back per the predictor FSM.
- flush_req with set 0 populated → busy high for exactly 8 cycles; a concurrent update_valid is dropped; afterwards all lookups miss and LRU=0x00.
- rst_n low during FLUSH cycle 3, then release → busy=0, IDLE, all misses; a new update succeeds normally.
